// File: rtl/dwt_pkg.sv
//==============================================================================
// Package : dwt_pkg
// Brief   : Shared constants, beat tag type and pass-limit helper for the
//           Haar MAC responder and its ordering checker.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package dwt_pkg;

    localparam logic [7:0] HAAR_OFFSET = 8'd128;

    // Tags are carried at a fixed width and trimmed to PTR_W at the outputs.
    localparam int TAG_PTR_W = 16;

    typedef enum logic {
        PASS_ROW = 1'b0,
        PASS_COL = 1'b1
    } pass_mode_e;

    typedef struct packed {
        logic                 mode;
        logic [TAG_PTR_W-1:0] row_column_pointer;
        logic [TAG_PTR_W-1:0] pixel_pointer;
        logic                 pass_end;
    } beat_tag_t;

    typedef struct packed {
        logic [TAG_PTR_W-1:0] pix_last;
        logic [TAG_PTR_W-1:0] line_last;
    } pass_lim_t;

    // Last pixel pointer and last line of a pass at the given level (div = 2^level).
    function automatic pass_lim_t pass_limits(
        input logic       mode,
        input logic [2:0] level,
        input int         width,
        input int         height
    );
        pass_lim_t lim;
        int        pix_span;
        int        line_span;
        pix_span      = (mode ? height : width) >> level;
        line_span     = (mode ? width : height) >> level;
        lim.pix_last  = TAG_PTR_W'(pix_span - 2);
        lim.line_last = TAG_PTR_W'(line_span - 1);
        return lim;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dwt_haar_seq_check.sv
//==============================================================================
// Module : dwt_haar_seq_check
// Brief  : Sticky beat-ordering checker; tracks the expected {mode,row,pixel}
//          and flags any out-of-order beat or any beat after the last level.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module dwt_haar_seq_check
    import dwt_pkg::*;
#(
    parameter  int HEIGHT              = 256,
    parameter  int WIDTH               = 256,
    parameter  int DECOMPOSITION_LEVEL = 1,
    localparam int PTR_W               = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_mode,
    input  logic [PTR_W-1:0] i_row,
    input  logic [PTR_W-1:0] i_pix,
    input  logic [2:0]       i_level,
    output logic             o_seq_err
);

    localparam logic [2:0] c_LAST_LEVEL = 3'(DECOMPOSITION_LEVEL);

    pass_mode_e       r_exp_mode;
    logic [PTR_W-1:0] r_exp_row;
    logic [PTR_W-1:0] r_exp_pix;
    logic             r_err;

    pass_lim_t w_lim;
    logic      w_pix_wrap;
    logic      w_line_end;
    logic      w_mismatch;

    // Level comes from the shared tracker, so limits switch on the beat after a column-pass end.
    always_comb begin
        w_lim      = pass_limits(r_exp_mode, i_level, WIDTH, HEIGHT);
        w_pix_wrap = (TAG_PTR_W'(r_exp_pix) == w_lim.pix_last);
        w_line_end = (TAG_PTR_W'(r_exp_row) == w_lim.line_last);
        w_mismatch = i_valid &&
                     (({i_mode, i_row, i_pix} != {r_exp_mode, r_exp_row, r_exp_pix}) ||
                      (i_level >= c_LAST_LEVEL));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exp_mode <= PASS_ROW;
            r_exp_row  <= '0;
            r_exp_pix  <= '0;
            r_err      <= 1'b0;
        end else if (i_valid) begin
            if (w_pix_wrap) begin
                r_exp_pix <= '0;
                if (w_line_end) begin
                    r_exp_mode <= (r_exp_mode == PASS_ROW) ? PASS_COL : PASS_ROW;
                    r_exp_row  <= '0;
                end else begin
                    r_exp_row <= r_exp_row + PTR_W'(1);
                end
            end else begin
                r_exp_pix <= r_exp_pix + PTR_W'(2);
            end
            if (w_mismatch) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_seq_err = r_err;

endmodule

`default_nettype wire

// File: rtl/dwt_haar_mac.sv
//==============================================================================
// Module : dwt_haar_mac
// Brief  : 3-stage Haar lifting MAC (floor average / offset half-difference)
//          with pass/level tracking and completion status.
// Config : define DWT_HAAR_SEQ_CHECK_EN to include the beat-ordering checker.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module dwt_haar_mac
    import dwt_pkg::*;
#(
    parameter  int HEIGHT              = 256,
    parameter  int WIDTH               = 256,
    parameter  int DECOMPOSITION_LEVEL = 1,
    localparam int PTR_W               = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      i_mac,
    input  logic             i_mac_valid,
    input  logic             i_mac_mode,
    input  logic [PTR_W-1:0] i_mac_row_column_pointer,
    input  logic [PTR_W-1:0] i_mac_pixel_pointer,
    output logic [15:0]      o_mac,
    output logic             o_mac_valid,
    output logic             o_mac_mode,
    output logic [PTR_W-1:0] o_mac_row_column_pointer,
    output logic [PTR_W-1:0] o_mac_pixel_pointer,
    output logic             o_pass_done,
    output logic [2:0]       o_level,
    output logic             o_done,
    output logic             o_seq_err
);

    localparam logic [2:0] c_LAST_LEVEL = 3'(DECOMPOSITION_LEVEL);

    logic        r_v1;
    logic [7:0]  r_a1;
    logic [7:0]  r_b1;
    beat_tag_t   r_tag1;

    logic              r_v2;
    logic [8:0]        r_sum2;
    logic signed [8:0] r_diff2;
    beat_tag_t         r_tag2;

    logic        r_v3;
    logic [7:0]  r_low3;
    logic [7:0]  r_high3;
    beat_tag_t   r_tag3;

    logic [2:0]  r_level;
    logic        r_done;

    pass_lim_t   w_lim;
    logic        w_final_beat;
    beat_tag_t   w_tag_in;
    logic [7:0]  w_high;

    always_comb begin
        w_lim        = pass_limits(i_mac_mode, r_level, WIDTH, HEIGHT);
        w_final_beat = i_mac_valid &&
                       (TAG_PTR_W'(i_mac_pixel_pointer) == w_lim.pix_last) &&
                       (TAG_PTR_W'(i_mac_row_column_pointer) == w_lim.line_last);
        w_tag_in                    = '0;
        w_tag_in.mode               = i_mac_mode;
        w_tag_in.row_column_pointer = TAG_PTR_W'(i_mac_row_column_pointer);
        w_tag_in.pixel_pointer      = TAG_PTR_W'(i_mac_pixel_pointer);
        w_tag_in.pass_end           = w_final_beat;
    end

    // Half-difference lies in -128..127, so the offset result always fits 8 bits.
    assign w_high = 8'(r_diff2 >>> 1) + HAAR_OFFSET;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1    <= 1'b0;
            r_a1    <= '0;
            r_b1    <= '0;
            r_tag1  <= '0;
            r_v2    <= 1'b0;
            r_sum2  <= '0;
            r_diff2 <= '0;
            r_tag2  <= '0;
            r_v3    <= 1'b0;
            r_low3  <= '0;
            r_high3 <= '0;
            r_tag3  <= '0;
        end else begin
            r_v1    <= i_mac_valid;
            r_a1    <= i_mac[15:8];
            r_b1    <= i_mac[7:0];
            r_tag1  <= w_tag_in;
            r_v2    <= r_v1;
            r_sum2  <= {1'b0, r_a1} + {1'b0, r_b1};
            r_diff2 <= $signed({1'b0, r_a1}) - $signed({1'b0, r_b1});
            r_tag2  <= r_tag1;
            r_v3    <= r_v2;
            r_low3  <= 8'(r_sum2 >> 1);
            r_high3 <= w_high;
            r_tag3  <= r_tag2;
        end
    end

    // Level saturates at the configured depth; done waits for that pass to drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= '0;
            r_done  <= 1'b0;
        end else begin
            if (w_final_beat && i_mac_mode && (r_level != c_LAST_LEVEL)) begin
                r_level <= r_level + 3'd1;
            end
            if (o_pass_done && r_tag3.mode && (r_level == c_LAST_LEVEL)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_mac                    = {r_low3, r_high3};
    assign o_mac_valid              = r_v3;
    assign o_mac_mode               = r_tag3.mode;
    assign o_mac_row_column_pointer = PTR_W'(r_tag3.row_column_pointer);
    assign o_mac_pixel_pointer      = PTR_W'(r_tag3.pixel_pointer);
    assign o_pass_done              = r_v3 && r_tag3.pass_end;
    assign o_level                  = r_level;
    assign o_done                   = r_done;

`ifdef DWT_HAAR_SEQ_CHECK_EN
    dwt_haar_seq_check #(
        .HEIGHT              (HEIGHT),
        .WIDTH               (WIDTH),
        .DECOMPOSITION_LEVEL (DECOMPOSITION_LEVEL)
    ) u_seq_check (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_mac_valid),
        .i_mode    (i_mac_mode),
        .i_row     (i_mac_row_column_pointer),
        .i_pix     (i_mac_pixel_pointer),
        .i_level   (r_level),
        .o_seq_err (o_seq_err)
    );
`else
    assign o_seq_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dwt_haar_mac.sv
//==============================================================================
// Module : tb_dwt_haar_mac
// Brief  : Self-checking bench for dwt_haar_mac (4x4 image, one level) against
//          a per-beat reference model with due-cycle scheduling.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dwt_haar_mac;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DL = 1;
    localparam int PW = $clog2(W);
`ifdef DWT_HAAR_SEQ_CHECK_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   i_mac;
    logic          i_mac_valid;
    logic          i_mac_mode;
    logic [PW-1:0] i_row;
    logic [PW-1:0] i_pix;
    logic [15:0]   o_mac;
    logic          o_mac_valid;
    logic          o_mac_mode;
    logic [PW-1:0] o_row;
    logic [PW-1:0] o_pix;
    logic          o_pass_done;
    logic [2:0]    o_level;
    logic          o_done;
    logic          o_seq_err;

    dwt_haar_mac #(
        .HEIGHT              (H),
        .WIDTH               (W),
        .DECOMPOSITION_LEVEL (DL)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .i_mac                    (i_mac),
        .i_mac_valid              (i_mac_valid),
        .i_mac_mode               (i_mac_mode),
        .i_mac_row_column_pointer (i_row),
        .i_mac_pixel_pointer      (i_pix),
        .o_mac                    (o_mac),
        .o_mac_valid              (o_mac_valid),
        .o_mac_mode               (o_mac_mode),
        .o_mac_row_column_pointer (o_row),
        .o_mac_pixel_pointer      (o_pix),
        .o_pass_done              (o_pass_done),
        .o_level                  (o_level),
        .o_done                   (o_done),
        .o_seq_err                (o_seq_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic        mode;
        int          row;
        int          pix;
        logic        pe;
    } exp_t;

    exp_t q[$];
    int   lvl_due[$];
    int   done_due = -1;
    int   err_due  = -1;
    int   beat_idx = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int haar(input int a, input int b);
        int lo;
        int hi;
        lo = (a + b) >>> 1;
        hi = ((a - b) >>> 1) + 128;
        return (lo << 8) | (hi & 255);
    endfunction

    function automatic bit is_final(input logic mode, input int row, input int pix, input int lvl);
        int pspan;
        int lspan;
        pspan = (mode ? H : W) >> lvl;
        lspan = (mode ? W : H) >> lvl;
        return (pix == pspan - 2) && (row == lspan - 1);
    endfunction

    // Legal order: per level, every row pass beat then every column pass beat, raster order.
    function automatic bit in_order(input int idx, input logic mode, input int row, input int pix);
        int rem;
        int pairs;
        int lines;
        rem = idx;
        for (int l = 0; l < DL; l++) begin
            for (int m = 0; m < 2; m++) begin
                pairs = ((m != 0 ? H : W) >> l) / 2;
                lines = (m != 0 ? W : H) >> l;
                if (rem < pairs * lines)
                    return (mode == (m != 0)) && (row == rem / pairs) && (pix == 2 * (rem % pairs));
                rem -= pairs * lines;
            end
        end
        return 1'b0;
    endfunction

    task automatic clear_model();
        q.delete();
        lvl_due.delete();
        done_due = -1;
        err_due  = -1;
        beat_idx = 0;
    endtask

    task automatic beat(input int a, input int b, input logic mode, input int row, input int pix,
                        input int exp_data);
        exp_t e;
        int   lvl;
        lvl         = lvl_due.size();
        i_mac       = {8'(a), 8'(b)};
        i_mac_valid = 1'b1;
        i_mac_mode  = mode;
        i_row       = PW'(row);
        i_pix       = PW'(pix);
        e.due  = cyc + 3;
        e.data = 16'(exp_data);
        e.mode = mode;
        e.row  = row;
        e.pix  = pix;
        e.pe   = is_final(mode, row, pix, lvl);
        q.push_back(e);
        if (e.pe && mode && lvl < DL) begin
            lvl_due.push_back(cyc + 1);
            if (lvl + 1 == DL) done_due = cyc + 4;
        end
        if (!in_order(beat_idx, mode, row, pix) && err_due < 0) err_due = cyc + 1;
        beat_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_beat(input logic mode, input int row, input int pix);
        int a;
        int b;
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        beat(a, b, mode, row, pix, haar(a, b));
    endtask

    task automatic idle(input int n);
        i_mac_valid = 1'b0;
        i_mac       = 16'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_mac_valid = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin : p_scoreboard
        bit   exp_v;
        int   lvl;
        exp_t e;
        exp_v = (q.size() > 0) && (q[0].due == cyc);
        check("valid", 32'(o_mac_valid), 32'(exp_v));
        if (exp_v) begin
            e = q.pop_front();
            check("data", 32'(o_mac), 32'(e.data));
            check("mode", 32'(o_mac_mode), 32'(e.mode));
            check("row", 32'(o_row), 32'(e.row));
            check("pix", 32'(o_pix), 32'(e.pix));
            check("pass_done", 32'(o_pass_done), 32'(e.pe));
        end else begin
            check("pass_done_idle", 32'(o_pass_done), 32'd0);
        end
        lvl = 0;
        foreach (lvl_due[i]) if (lvl_due[i] <= cyc) lvl++;
        check("level", 32'(o_level), 32'(lvl));
        check("done", 32'(o_done), 32'(done_due >= 0 && cyc >= done_due));
        check("seq_err", 32'(o_seq_err), 32'(SEQ_ON && err_due >= 0 && cyc >= err_due));
    end

    initial begin
        rst         = 1'b0;
        i_mac       = '0;
        i_mac_valid = 1'b0;
        i_mac_mode  = 1'b0;
        i_row       = '0;
        i_pix       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(o_mac_valid), 32'd0);
        check("rst_mac", 32'(o_mac), 32'd0);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        rst = 1'b1;
        idle(2);

        // Directed arithmetic, spaced so each result stands alone.
        beat(200, 100, 1'b0, 0, 0, 32'h96B2); idle(4);
        beat(0, 255, 1'b0, 0, 2, 32'h7F00);   idle(4);
        beat(255, 0, 1'b1, 2, 0, 32'h7FFF);   idle(4);
        beat(7, 7, 1'b0, 3, 2, 32'h0780);     idle(5);

        // Full level: row pass then column pass, back to back.
        do_reset();
        idle(1);
        for (int r = 0; r < H; r++)
            for (int p = 0; p < W; p += 2) rnd_beat(1'b0, r, p);
        for (int c = 0; c < W; c++)
            for (int p = 0; p < H; p += 2) rnd_beat(1'b1, c, p);
        idle(6);
        check("full_level", 32'(o_level), 32'd1);
        check("full_done", 32'(o_done), 32'd1);
        check("full_seq_err", 32'(o_seq_err), 32'd0);

        // Ordering error: second beat repeats pixel 0.
        do_reset();
        idle(1);
        beat(10, 20, 1'b0, 0, 0, haar(10, 20));
        beat(30, 5, 1'b0, 0, 0, haar(30, 5));
        idle(6);
        check("ord_seq_err", 32'(o_seq_err), 32'(SEQ_ON));

        // Throughput: 16 contiguous, 3 idle, 4 more.
        do_reset();
        idle(1);
        repeat (16) rnd_beat(1'b0, int'($urandom_range(0, H - 1)), 2 * int'($urandom_range(0, W / 2 - 1)));
        idle(3);
        repeat (4) rnd_beat(1'b0, int'($urandom_range(0, H - 1)), 2 * int'($urandom_range(0, W / 2 - 1)));
        idle(6);

        // Asynchronous reset with beats in flight.
        do_reset();
        idle(1);
        rnd_beat(1'b0, 0, 0);
        rnd_beat(1'b0, 0, 2);
        idle(1);
        check("flight_valid", 32'(o_mac_valid), 32'd1);
        rst = 1'b0;
        clear_model();
        #1;
        check("async_flush", 32'(o_mac_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(8);
        check("post_rst_level", 32'(o_level), 32'd0);
        check("post_rst_done", 32'(o_done), 32'd0);
        check("post_rst_seq_err", 32'(o_seq_err), 32'd0);

        // Random row-pass traffic with random bubbles.
        do_reset();
        idle(1);
        repeat (300) begin
            if ($urandom_range(0, 9) < 6)
                rnd_beat(1'b0, int'($urandom_range(0, H - 1)), 2 * int'($urandom_range(0, W / 2 - 1)));
            else
                idle(1);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dwt_haar_mac.md
# dwt_haar_mac

Arithmetic responder for the 2D DWT engine: accepts the pixel-pair beats issued by the DWT control logic, computes one Haar lifting step per beat (low = floor average, high = offset-binary half-difference), and returns the coefficient pair tagged with the original mode and pointers so the control logic can form write addresses. It is fully pipelined at one beat per cycle with fixed latency. It also independently tracks pass and level progress, emits pass and level-completion status, and optionally checks beat ordering.

## Interface
Parameters:
- HEIGHT, 256, image rows (power of two, HEIGHT <= WIDTH)
- WIDTH, 256, image columns (power of two)
- DECOMPOSITION_LEVEL, 1, number of row+column pass pairs
- PTR_W, $clog2(WIDTH), pointer width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_mac  in  16  {a[15:8], b[7:0]}, unsigned pixels
- i_mac_valid  in  1  beat valid
- i_mac_mode  in  1  0 = row pass, 1 = column pass
- i_mac_row_column_pointer  in  PTR_W  row (mode 0) or column (mode 1)
- i_mac_pixel_pointer  in  PTR_W  even index of a within the line
- o_mac  out  16  {low[15:8], high[7:0]}
- o_mac_valid  out  1  result valid
- o_mac_mode, o_mac_row_column_pointer, o_mac_pixel_pointer  out  1/PTR_W/PTR_W  tags delayed with the beat
- o_pass_done  out  1  one-cycle pulse with the final result beat of a pass
- o_level  out  3  completed levels
- o_done  out  1  sticky: all levels complete and the pipeline drained
- o_seq_err  out  1  sticky ordering error

## Operation
- Stage 1: register the pair, tags, and valid. Stage 2: sum = a+b (9-bit unsigned), diff = a-b (9-bit signed). Stage 3: low = sum>>1; high = (diff>>>1)+128, truncated to 8 bits. The range is exactly 0..255, so no saturation is needed.
- No backpressure. Every valid beat produces exactly one result. Invalid cycles produce bubbles with o_mac_valid=0.
- The level tracker keeps div = 2^level internally.
  - Row-pass final beat: mode 0, pixel = WIDTH/div-2, row = HEIGHT/div-1.
  - Column-pass final beat: mode 1, pixel = HEIGHT/div-2, col = WIDTH/div-1.
- On a final input beat, a pass_end flag travels with the beat through the pipeline.
- On acceptance of a column-pass final beat, level increments.
- o_pass_done = stage-3 valid AND pass_end.
- o_done sets the cycle after the last beat of level DECOMPOSITION_LEVEL leaves stage 3.
- Reset values: all outputs 0, level 0, pipeline valids 0. Reset mid-operation discards in-flight beats immediately, and no partial output appears.

## Timing
- Latency is 3 cycles: an input valid at edge N gives o_mac_valid high after edge N+3. Back-to-back beats give back-to-back results.
- Tags, pass_end, and data stay aligned in every stage.
- o_level updates one cycle after the column-pass final beat is accepted at the input.
- When the final beat is accepted in the same cycle that another beat exits, both events take effect independently.
- The checker's expected-pointer state advances only on i_mac_valid.

## Configuration
- DWT_HAAR_SEQ_CHECK_EN defined:
  - Expected {mode, row, pixel} starts at {0,0,0}.
  - Pixel steps by 2 and wraps at the pass limit, then row increments.
  - At the pass end, mode toggles and pointers restart at 0.
  - Any valid beat that mismatches the expectation, or arrives after level reaches DECOMPOSITION_LEVEL, sets o_seq_err on the next edge. It holds until reset.
  - The mismatching beat is still processed.
- Undefined: the checker is absent and o_seq_err is tied to 0. Datapath, pass, and level logic are unchanged.

## Structure
- dwt_pkg holds:
  - HAAR_OFFSET = 8'd128
  - a typedef beat_tag_t {mode, row_column_pointer, pixel_pointer, pass_end}
  - a function returning pass limits for (mode, level)
- The ordering checker is one sub-module, dwt_haar_seq_check, instantiated under DWT_HAAR_SEQ_CHECK_EN.

## Test plan
- Arithmetic. Single beats:
  - {200,100} -> 0x96B2
  - {0,255} -> 0x7F00
  - {255,0} -> 0x7FFF
  - {7,7} -> 0x0780
  - Each result appears exactly 3 cycles after its input, with tags echoed.
- Throughput. 16 back-to-back beats followed by 3 idle cycles, then 4 beats -> 16 contiguous results, 3-cycle gap, 4 results, order preserved.
- Full pass sequence, WIDTH=HEIGHT=4, LEVEL=1:
  - 8 mode-0 beats then 8 mode-1 beats in order.
  - o_pass_done pulses with result beats 8 and 16.
  - o_level becomes 1.
  - o_done sets; o_seq_err stays 0.
- Ordering error (macro on): the second beat carries pixel_pointer 0 instead of 2 -> o_seq_err rises the next cycle, stays high, and the data result is still produced.
- Reset mid-flight: assert rst with 2 beats in the pipeline -> o_mac_valid=0 immediately, no results after release, and level, o_done, o_seq_err all 0.
